vec_exec_lanes: RTL and testbench
=================================

// Module: vec_exec_lanes
// PURPOSE
//  Parametrised SIMD execute stage for the vector/scalar pipeline. It replaces the hand-instantiated bank of per-lane ALUs.
//  Accepts one operation per cycle on a valid/ready handshake and computes all lanes in parallel.
//  Adds per-lane masking, scalar-broadcast of operand B, and a multi-cycle cross-lane reduction (RSUM).
//  Registered result and NZCV flags go to the EX/MEM pipeline register. The scalar lane is lane LANES-1.
// PARAMETERS
//  LANES   16  number of lanes; power of two, >=2
//  DATA_W  32  bits per lane
//  LOG2L   $clog2(LANES)  reduction depth (derived, not overridden)
// PORTS
//  clk         in   1               clock, rising edge
//  rst         in   1               asynchronous, active-low reset
//  in_valid    in   1               operation presented
//  in_ready    out  1               stage can accept this cycle
//  op          in   3               000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL(low DATA_W), 101 SLL, 110 SRL, 111 RSUM
//  vec_scalar  in   1               1 = vector (all unmasked lanes); 0 = scalar (lane LANES-1 only)
//  lane_mask   in   LANES           1 = lane active (vector mode only)
//  bcast_b     in   1               1 = src_b[LANES-1] replicated to every lane (immediate/scalar operand)
//  src_a       in   LANES x DATA_W  operand A
//  src_b       in   LANES x DATA_W  operand B; shift amount = src_b[lane][$clog2(DATA_W)-1:0]
//  out_valid   out  1               result registered and valid
//  out_ready   in   1               downstream accepts result
//  result      out  LANES x DATA_W  lane results
//  flags       out  4               {N,Z,C,V} of lane LANES-1
//  busy        out  1               RSUM in progress
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): state IDLE; out_valid=0; busy=0; result=0; flags=0; reduction counter=0.
//  - in_ready = (state==IDLE) && (!out_valid || out_ready). The op is accepted on a clock edge with in_valid && in_ready.
//  - Output hold: while out_valid && !out_ready, result and flags are held stable.
//    out_valid clears on an out_ready edge unless a new result is written on that same edge.
//  - Lane activity:
//    - vector mode: lane i active iff lane_mask[i].
//    - scalar mode: only lane LANES-1 is active; lane_mask is ignored.
//    - Inactive lanes output 0.
//  - Arithmetic: modulo 2^DATA_W. SLL and SRL are logical; shift amount >= DATA_W is impossible by construction (field width).
//  - Flags from lane LANES-1, including when that lane is masked (result 0 then gives Z=1):
//    - N = msb.
//    - Z = (lane==0).
//    - ADD: C = carry-out; V = signed overflow.
//    - SUB: C = NOT borrow (a>=b unsigned); V = signed overflow.
//    - All other ops: C=0, V=0.
//  - Simple ops (000-110): on the accept edge, result, flags and out_valid are written. Latency is 1 edge; throughput is 1 per cycle.
//  - RSUM FSM:
//    - Input: active lanes of src_a; src_b and bcast_b are ignored. Inactive lanes load as 0.
//    - IDLE -> REDUCE on the accept edge: acc[i] = active ? src_a[i] : 0; cnt=0; busy=1.
//    - REDUCE, each edge: acc[i] <= acc[2i] + acc[2i+1] for i < LANES>>(cnt+1); cnt++.
//    - On the edge where cnt==LOG2L-1:
//      - result[LANES-1] = final sum; other lanes = 0.
//      - N and Z are set from the sum; C=V=0.
//      - out_valid=1; busy=0; state -> IDLE.
//    - REDUCE does not wait for out_ready: in_ready=0 throughout REDUCE, and the previous result has already left.
//    - Latency: LOG2L edges after the accept edge. Scalar-mode RSUM returns src_a[LANES-1] with the same latency.
//  - Back-to-back: an RSUM cannot be accepted while an unconsumed result is held. A simple op accepted on the RSUM's final edge is impossible (in_ready=0).
//  - Reset mid-RSUM: the reduction is abandoned and no result is produced. in_ready=1 from the first edge after reset release.
//  - No combinational path from in_* to out_*. in_ready depends only on state, out_valid and out_ready.
// TESTING
//  1 Reset: hold rst=0, then release -> out_valid=0, busy=0, result=0, flags=0, in_ready=1.
//  2 ADD, vector, mask=all 1s, a[i]=i, b[i]=100 -> next cycle result[i]=100+i.
//    Also: a[15]=32'h7FFFFFFF, b[15]=1 -> flags N=1, Z=0, C=0, V=1.
//  3 SUB, scalar, a[15]=5, b[15]=5, other lanes nonzero -> result[15]=0, lanes 0-14 = 0, flags Z=1, C=1.
//  4 RSUM, vector, mask=16'h00FF, a[i]=i+1 -> out_valid exactly 4 edges after accept.
//    result[15]=36, others 0, busy high for 4 cycles, in_ready=0 throughout.
//  5 Stall: out_ready=0 for 3 cycles with 2 ADDs offered -> first result held stable, second not accepted.
//    out_ready=1 -> both results delivered in order, no loss or duplication.
//  6 RSUM with a[i]=32'hFFFFFFFF on all lanes, then rst pulsed low at cnt=2 -> out_valid stays 0.
//    The next RSUM then completes with 32'hFFFFFFF0 (wrap).

Source files
------------

// File: rtl/vec_exec_lanes.sv
// SIMD execute stage: per-lane ALU ops in 1 edge, RSUM tree reduction in LOG2L edges.
// Accepts only when IDLE and the output register is empty or draining; holds result while out_ready=0.
module vec_exec_lanes #(
   parameter int LANES  = 16,
   parameter int DATA_W = 32,
   localparam int LOG2L = $clog2(LANES),
   localparam int SHW   = $clog2(DATA_W)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [2:0]                     op,
   input  logic                           vec_scalar,
   input  logic [LANES-1:0]               lane_mask,
   input  logic                           bcast_b,
   input  logic [LANES-1:0][DATA_W-1:0]   src_a,
   input  logic [LANES-1:0][DATA_W-1:0]   src_b,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [LANES-1:0][DATA_W-1:0]   result,
   output logic [3:0]                     flags,
   output logic                           busy
);

   typedef enum logic {S_IDLE, S_REDUCE} state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_ORR  = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;
   localparam logic [2:0] OP_SLL  = 3'b101;
   localparam logic [2:0] OP_SRL  = 3'b110;
   localparam logic [2:0] OP_RSUM = 3'b111;

   state_t                         state_q, state_d;
   logic [LOG2L-1:0]               cnt_q, cnt_d;
   logic [LANES-1:0][DATA_W-1:0]   acc_q, acc_d;
   logic                           out_valid_q, out_valid_d;
   logic [LANES-1:0][DATA_W-1:0]   result_q, result_d;
   logic [3:0]                     flags_q, flags_d;

   logic [LANES-1:0]               active;
   logic [LANES-1:0][DATA_W-1:0]   b_eff;
   logic [LANES-1:0][DATA_W-1:0]   lane_res;
   logic [DATA_W-1:0]              a_t, b_t, r_t;
   logic                           c_t, v_t;
   logic                           accept;

   assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      active   = '0;
      b_eff    = '0;
      lane_res = '0;
      for (int i = 0; i < LANES; i++) begin
         active[i] = vec_scalar ? lane_mask[i] : (i == LANES-1);
         b_eff[i]  = bcast_b ? src_b[LANES-1] : src_b[i];
         case (op)
            OP_ADD:  lane_res[i] = src_a[i] + b_eff[i];
            OP_SUB:  lane_res[i] = src_a[i] - b_eff[i];
            OP_AND:  lane_res[i] = src_a[i] & b_eff[i];
            OP_ORR:  lane_res[i] = src_a[i] | b_eff[i];
            OP_MUL:  lane_res[i] = src_a[i] * b_eff[i];
            OP_SLL:  lane_res[i] = src_a[i] << b_eff[i][SHW-1:0];
            OP_SRL:  lane_res[i] = src_a[i] >> b_eff[i][SHW-1:0];
            default: lane_res[i] = '0;
         endcase
         if (!active[i]) begin
            lane_res[i] = '0;
         end
      end
   end

   // Carry/overflow of the scalar lane; a masked scalar lane reports C=V=0.
   always_comb begin
      a_t = src_a[LANES-1];
      b_t = b_eff[LANES-1];
      r_t = lane_res[LANES-1];
      c_t = 1'b0;
      v_t = 1'b0;
      if (active[LANES-1]) begin
         if (op == OP_ADD) begin
            c_t = 1'(({1'b0, a_t} + {1'b0, b_t}) >> DATA_W);
            v_t = (a_t[DATA_W-1] == b_t[DATA_W-1]) && (r_t[DATA_W-1] != a_t[DATA_W-1]);
         end else if (op == OP_SUB) begin
            c_t = (a_t >= b_t);
            v_t = (a_t[DATA_W-1] != b_t[DATA_W-1]) && (r_t[DATA_W-1] != a_t[DATA_W-1]);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q && !out_ready;
      result_d    = result_q;
      flags_d     = flags_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (op == OP_RSUM) begin
                  for (int i = 0; i < LANES; i++) begin
                     acc_d[i] = active[i] ? src_a[i] : '0;
                  end
                  cnt_d   = '0;
                  state_d = S_REDUCE;
               end else begin
                  result_d    = lane_res;
                  flags_d     = {r_t[DATA_W-1], (r_t == '0), c_t, v_t};
                  out_valid_d = 1'b1;
               end
            end
         end
         default: begin
            // Pairwise tree: live width halves every edge.
            for (int i = 0; i < LANES/2; i++) begin
               if (i < (LANES >> (cnt_q + 1))) begin
                  acc_d[i] = acc_q[2*i] + acc_q[2*i+1];
               end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LOG2L'(LOG2L-1)) begin
               result_d          = '0;
               result_d[LANES-1] = acc_d[0];
               flags_d           = {acc_d[0][DATA_W-1], (acc_d[0] == '0), 2'b00};
               out_valid_d       = 1'b1;
               state_d           = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign busy      = (state_q == S_REDUCE);

endmodule

// File: tb/tb_vec_exec_lanes.sv
// Bench for vec_exec_lanes: scenario tasks plus an in-order scoreboard of delivered results.
module tb_vec_exec_lanes;

   typedef logic [15:0][31:0] vec_t;
   typedef struct packed {
      vec_t       res;
      logic [3:0] fl;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = 3'd0;
   logic        vec_scalar = 1'b1;
   logic [15:0] lane_mask = '0;
   logic        bcast_b = 1'b0;
   vec_t        src_a = '0;
   vec_t        src_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   vec_t        result;
   logic [3:0]  flags;
   logic        busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   exp_t e_mon;

   vec_exec_lanes #(.LANES(16), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .vec_scalar(vec_scalar), .lane_mask(lane_mask), .bcast_b(bcast_b),
      .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model for ops 000-110 using wide integer arithmetic.
   function automatic exp_t model_simple(input logic [2:0] o, input logic vs, input logic [15:0] m,
                                         input logic bb, input vec_t a, input vec_t b);
      exp_t        ex;
      logic [31:0] bv;
      logic [31:0] r;
      logic        act;
      longint      s;
      longint unsigned u;
      ex = '0;
      for (int i = 0; i < 16; i++) begin
         act = vs ? m[i] : (i == 15);
         bv  = bb ? b[15] : b[i];
         case (o)
            3'd0: r = a[i] + bv;
            3'd1: r = a[i] - bv;
            3'd2: r = a[i] & bv;
            3'd3: r = a[i] | bv;
            3'd4: r = 32'(longint'(a[i]) * longint'(bv));
            3'd5: r = a[i] << bv[4:0];
            3'd6: r = a[i] >> bv[4:0];
            default: r = '0;
         endcase
         ex.res[i] = act ? r : 32'd0;
      end
      ex.fl[3] = ex.res[15][31];
      ex.fl[2] = (ex.res[15] == 32'd0);
      act = vs ? m[15] : 1'b1;
      bv  = bb ? b[15] : b[15];
      if (act && o == 3'd0) begin
         u = longint'(a[15]) + longint'(bv);
         ex.fl[1] = (u > 64'h0000_0000_FFFF_FFFF);
         s = longint'($signed(a[15])) + longint'($signed(bv));
         ex.fl[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end else if (act && o == 3'd1) begin
         ex.fl[1] = (a[15] >= bv);
         s = longint'($signed(a[15])) - longint'($signed(bv));
         ex.fl[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      return ex;
   endfunction

   // Scoreboard: every handshake-completing output is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output result=%h flags=%b required no output", result, flags);
         end else begin
            e_mon = sb.pop_front();
            if (result !== e_mon.res || flags !== e_mon.fl) begin
               n_fail++;
               $display("FAIL scoreboard got result=%h flags=%b required result=%h flags=%b",
                        result, flags, e_mon.res, e_mon.fl);
            end
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic vs, input logic [15:0] m,
                        input logic bb, input vec_t a, input vec_t b);
      bit got;
      got = 0;
      @(posedge clk); #2;
      op = o; vec_scalar = vs; lane_mask = m; bcast_b = bb; src_a = a; src_b = b;
      in_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL issue_timeout in_ready=0 required 1");
      end
      @(posedge clk); #2;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b required=0", busy); end
      n_checks++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got=%h required=0", result); end
      n_checks++; if (flags !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b required=0000", flags); end
      @(posedge clk); #2;
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
   endtask

   task automatic test_add();
      vec_t a, b;
      for (int i = 0; i < 16; i++) begin a[i] = i; b[i] = 100; end
      a[15] = 32'h7FFF_FFFF; b[15] = 32'd1;
      sb.push_back(model_simple(3'd0, 1'b1, 16'hFFFF, 1'b0, a, b));
      issue(3'd0, 1'b1, 16'hFFFF, 1'b0, a, b);
      @(negedge clk);
      n_checks++; if (flags !== 4'b1001) begin n_fail++; $display("FAIL add_overflow_flags got=%b required=1001", flags); end
      n_checks++; if (result[3] !== 32'd103) begin n_fail++; $display("FAIL add_lane3 got=%0d required=103", result[3]); end
      a[15] = 32'hFFFF_FFFF;
      sb.push_back(model_simple(3'd0, 1'b1, 16'hFFFF, 1'b0, a, b));
      issue(3'd0, 1'b1, 16'hFFFF, 1'b0, a, b);
      @(negedge clk);
      n_checks++; if (flags !== 4'b0110) begin n_fail++; $display("FAIL add_carry_flags got=%b required=0110", flags); end
   endtask

   task automatic test_sub_scalar();
      vec_t a, b;
      for (int i = 0; i < 16; i++) begin a[i] = 32'd77 + i; b[i] = 32'd3; end
      a[15] = 32'd5; b[15] = 32'd5;
      sb.push_back(model_simple(3'd1, 1'b0, 16'h0F0F, 1'b0, a, b));
      issue(3'd1, 1'b0, 16'h0F0F, 1'b0, a, b);
      @(negedge clk);
      n_checks++; if (flags !== 4'b0110) begin n_fail++; $display("FAIL sub_scalar_flags got=%b required=0110", flags); end
      n_checks++; if (result !== '0) begin n_fail++; $display("FAIL sub_scalar_result got=%h required=0", result); end
   endtask

   task automatic test_ops_random();
      vec_t a, b;
      logic [15:0] m;
      logic bb;
      for (int o = 0; o < 7; o++) begin
         for (int i = 0; i < 16; i++) begin a[i] = $urandom; b[i] = $urandom; end
         m  = 16'($urandom) | 16'h8000;
         bb = 1'(o % 2);
         sb.push_back(model_simple(3'(o), 1'b1, m, bb, a, b));
         issue(3'(o), 1'b1, m, bb, a, b);
      end
   endtask

   task automatic test_back_to_back();
      vec_t a, b;
      @(posedge clk); #2;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 16; i++) begin a[i] = $urandom; b[i] = k * 16 + i; end
         op = 3'(k); vec_scalar = 1'b1; lane_mask = 16'hFFFF; bcast_b = 1'b0;
         src_a = a; src_b = b; in_valid = 1'b1;
         sb.push_back(model_simple(3'(k), 1'b1, 16'hFFFF, 1'b0, a, b));
         @(negedge clk);
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cycle=%0d got=%b required=1", k, in_ready); end
         @(posedge clk); #2;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_rsum();
      vec_t a, z;
      exp_t ex;
      z = '0;
      for (int i = 0; i < 16; i++) a[i] = i + 1;
      ex = '0; ex.res[15] = 32'd36; ex.fl = 4'b0000;
      sb.push_back(ex);
      issue(3'd7, 1'b1, 16'h00FF, 1'b0, a, z);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rsum_reduce cycle=%0d busy=%b in_ready=%b out_valid=%b required 1,0,0", k, busy, in_ready, out_valid);
         end
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rsum_latency out_valid=%b busy=%b required 1,0", out_valid, busy);
      end
      for (int i = 0; i < 16; i++) a[i] = $urandom;
      ex = '0; ex.res[15] = a[15]; ex.fl = {a[15][31], (a[15] == 32'd0), 2'b00};
      sb.push_back(ex);
      issue(3'd7, 1'b0, 16'hFFFF, 1'b1, a, z);
      repeat (6) @(posedge clk);
   endtask

   task automatic test_stall();
      vec_t a1, b1, a2, b2;
      exp_t e1, e2;
      for (int i = 0; i < 16; i++) begin a1[i] = 1000 + i; b1[i] = i; a2[i] = 2000 + i; b2[i] = 7; end
      e1 = model_simple(3'd0, 1'b1, 16'hFFFF, 1'b0, a1, b1);
      e2 = model_simple(3'd0, 1'b1, 16'hFFFF, 1'b0, a2, b2);
      out_ready = 1'b0;
      sb.push_back(e1);
      issue(3'd0, 1'b1, 16'hFFFF, 1'b0, a1, b1);
      src_a = a2; src_b = b2; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== e1.res) begin
            n_fail++;
            $display("FAIL stall_hold cycle=%0d in_ready=%b out_valid=%b result=%h required 0,1,%h",
                     k, in_ready, out_valid, result, e1.res);
         end
      end
      @(posedge clk); #2;
      out_ready = 1'b1;
      sb.push_back(e2);
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release in_ready=%b required 1", in_ready); end
      @(posedge clk); #2;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_rsum_reset();
      vec_t a, z;
      exp_t ex;
      z = '0;
      for (int i = 0; i < 16; i++) a[i] = 32'hFFFF_FFFF;
      issue(3'd7, 1'b1, 16'hFFFF, 1'b0, a, z);
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rsum_async_reset busy=%b out_valid=%b required 0,0", busy, out_valid); end
      @(posedge clk); #2;
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rsum_abandon cycle=%0d out_valid=%b busy=%b in_ready=%b required 0,0,1", k, out_valid, busy, in_ready);
         end
      end
      ex = '0; ex.res[15] = 32'hFFFF_FFF0; ex.fl = 4'b1000;
      sb.push_back(ex);
      issue(3'd7, 1'b1, 16'hFFFF, 1'b0, a, z);
      repeat (6) @(posedge clk);
   endtask

   task automatic test_drain();
      for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL drain pending=%0d required 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_scalar();
      test_ops_random();
      test_back_to_back();
      test_rsum();
      test_stall();
      test_rsum_reset();
      test_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
